// File: rtl/sys_ctrl_pkg.sv
// Shared opcodes, operand addresses and FSM state encoding for the command decoder.
package sys_ctrl_pkg;

    localparam logic [7:0] CMD_RF_WR   = 8'hAA;
    localparam logic [7:0] CMD_RF_RD   = 8'hBB;
    localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
    localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

    localparam int unsigned OPA_ADDR = 0;
    localparam int unsigned OPB_ADDR = 1;

    typedef enum logic [3:0] {
        IDLE,
        WR_ADDR,
        WR_DATA,
        RD_ADDR,
        RD_WAIT,
        TX_RD,
        OPA,
        OPB,
        FUN,
        ALU_WAIT,
        TX_LSB,
        TX_MSB
    } state_e;

endpackage

// File: rtl/sys_ctrl_cmd.sv
// Command decoder between the UART RX byte stream and the register file, ALU and TX FIFO.
// Decodes framed AA/BB/CC/DD commands; every output is a flop.
module sys_ctrl_cmd
    import sys_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned ADDR_WIDTH    = 4,
    parameter int unsigned ALU_OUT_WIDTH = 16,
    parameter int unsigned FUN_WIDTH     = 4
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [DATA_WIDTH-1:0]    RX_P_DATA,
    input  logic                     RX_D_VLD,
    input  logic [DATA_WIDTH-1:0]    RdData,
    input  logic                     RdData_Valid,
    input  logic [ALU_OUT_WIDTH-1:0] ALU_OUT,
    input  logic                     ALU_OUT_VLD,
    input  logic                     FIFO_FULL,
    output logic                     WrEn,
    output logic                     RdEn,
    output logic [ADDR_WIDTH-1:0]    Address,
    output logic [DATA_WIDTH-1:0]    WrData,
    output logic                     ALU_EN,
    output logic [FUN_WIDTH-1:0]     ALU_FUN,
    output logic                     CLK_EN,
    output logic [DATA_WIDTH-1:0]    TX_P_DATA,
    output logic                     TX_D_VLD
);

    state_e                   r_state,     w_state_nxt;
    logic                     r_wr_en,     w_wr_en_nxt;
    logic                     r_rd_en,     w_rd_en_nxt;
    logic [ADDR_WIDTH-1:0]    r_addr,      w_addr_nxt;
    logic [DATA_WIDTH-1:0]    r_wr_data,   w_wr_data_nxt;
    logic                     r_alu_en,    w_alu_en_nxt;
    logic [FUN_WIDTH-1:0]     r_alu_fun,   w_alu_fun_nxt;
    logic                     r_clk_en,    w_clk_en_nxt;
    logic [DATA_WIDTH-1:0]    r_tx_data,   w_tx_data_nxt;
    logic                     r_tx_vld,    w_tx_vld_nxt;
    logic [DATA_WIDTH-1:0]    r_rd_byte,   w_rd_byte_nxt;
    logic [ALU_OUT_WIDTH-1:0] r_alu_res,   w_alu_res_nxt;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state   <= IDLE;
            r_wr_en   <= 1'b0;
            r_rd_en   <= 1'b0;
            r_addr    <= '0;
            r_wr_data <= '0;
            r_alu_en  <= 1'b0;
            r_alu_fun <= '0;
            r_clk_en  <= 1'b0;
            r_tx_data <= '0;
            r_tx_vld  <= 1'b0;
            r_rd_byte <= '0;
            r_alu_res <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_wr_en   <= w_wr_en_nxt;
            r_rd_en   <= w_rd_en_nxt;
            r_addr    <= w_addr_nxt;
            r_wr_data <= w_wr_data_nxt;
            r_alu_en  <= w_alu_en_nxt;
            r_alu_fun <= w_alu_fun_nxt;
            r_clk_en  <= w_clk_en_nxt;
            r_tx_data <= w_tx_data_nxt;
            r_tx_vld  <= w_tx_vld_nxt;
            r_rd_byte <= w_rd_byte_nxt;
            r_alu_res <= w_alu_res_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_wr_en_nxt   = 1'b0;
        w_rd_en_nxt   = 1'b0;
        w_alu_en_nxt  = 1'b0;
        w_tx_vld_nxt  = 1'b0;
        w_addr_nxt    = r_addr;
        w_wr_data_nxt = r_wr_data;
        w_alu_fun_nxt = r_alu_fun;
        w_clk_en_nxt  = r_clk_en;
        w_tx_data_nxt = r_tx_data;
        w_rd_byte_nxt = r_rd_byte;
        w_alu_res_nxt = r_alu_res;

        unique case (r_state)
            IDLE: begin
                if (RX_D_VLD) begin
                    case (RX_P_DATA)
                        CMD_RF_WR:   w_state_nxt = WR_ADDR;
                        CMD_RF_RD:   w_state_nxt = RD_ADDR;
                        CMD_ALU_OP:  w_state_nxt = OPA;
                        CMD_ALU_NOP: w_state_nxt = FUN;
                        default:     w_state_nxt = IDLE;
                    endcase
                end
            end
            WR_ADDR: begin
                if (RX_D_VLD) begin
                    w_addr_nxt  = RX_P_DATA[ADDR_WIDTH-1:0];
                    w_state_nxt = WR_DATA;
                end
            end
            WR_DATA: begin
                if (RX_D_VLD) begin
                    w_wr_data_nxt = RX_P_DATA;
                    w_wr_en_nxt   = 1'b1;
                    w_state_nxt   = IDLE;
                end
            end
            RD_ADDR: begin
                if (RX_D_VLD) begin
                    w_addr_nxt  = RX_P_DATA[ADDR_WIDTH-1:0];
                    w_rd_en_nxt = 1'b1;
                    w_state_nxt = RD_WAIT;
                end
            end
            RD_WAIT: begin
                // Send straight away when the FIFO has room; TX_RD only holds a stalled byte.
                if (RdData_Valid) begin
                    w_rd_byte_nxt = RdData;
                    if (!FIFO_FULL) begin
                        w_tx_data_nxt = RdData;
                        w_tx_vld_nxt  = 1'b1;
                        w_state_nxt   = IDLE;
                    end else begin
                        w_state_nxt   = TX_RD;
                    end
                end
            end
            TX_RD: begin
                if (!FIFO_FULL) begin
                    w_tx_data_nxt = r_rd_byte;
                    w_tx_vld_nxt  = 1'b1;
                    w_state_nxt   = IDLE;
                end
            end
            OPA: begin
                if (RX_D_VLD) begin
                    w_addr_nxt    = ADDR_WIDTH'(OPA_ADDR);
                    w_wr_data_nxt = RX_P_DATA;
                    w_wr_en_nxt   = 1'b1;
                    w_state_nxt   = OPB;
                end
            end
            OPB: begin
                if (RX_D_VLD) begin
                    w_addr_nxt    = ADDR_WIDTH'(OPB_ADDR);
                    w_wr_data_nxt = RX_P_DATA;
                    w_wr_en_nxt   = 1'b1;
                    w_state_nxt   = FUN;
                end
            end
            FUN: begin
                if (RX_D_VLD) begin
                    w_alu_fun_nxt = RX_P_DATA[FUN_WIDTH-1:0];
                    w_alu_en_nxt  = 1'b1;
                    w_clk_en_nxt  = 1'b1;
                    w_state_nxt   = ALU_WAIT;
                end
            end
            ALU_WAIT: begin
                if (ALU_OUT_VLD) begin
                    w_alu_res_nxt = ALU_OUT;
                    w_clk_en_nxt  = 1'b0;
                    w_state_nxt   = TX_LSB;
                end
            end
            TX_LSB: begin
                if (!FIFO_FULL) begin
                    w_tx_data_nxt = r_alu_res[DATA_WIDTH-1:0];
                    w_tx_vld_nxt  = 1'b1;
                    w_state_nxt   = TX_MSB;
                end
            end
            TX_MSB: begin
                // Waiting for r_tx_vld to clear keeps an idle cycle between the two bytes.
                if (!FIFO_FULL && !r_tx_vld) begin
                    w_tx_data_nxt = r_alu_res[ALU_OUT_WIDTH-1:DATA_WIDTH];
                    w_tx_vld_nxt  = 1'b1;
                    w_state_nxt   = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign WrEn      = r_wr_en;
    assign RdEn      = r_rd_en;
    assign Address   = r_addr;
    assign WrData    = r_wr_data;
    assign ALU_EN    = r_alu_en;
    assign ALU_FUN   = r_alu_fun;
    assign CLK_EN    = r_clk_en;
    assign TX_P_DATA = r_tx_data;
    assign TX_D_VLD  = r_tx_vld;

endmodule

// File: doc/sys_ctrl_cmd.md
Name: sys_ctrl_cmd

Overview:
- Command-decoder FSM that sits directly upstream of the 16x8 register file.
- Consumes parallel bytes from the UART RX deserialiser and decodes framed commands.
- Drives the register file write/read strobes, the ALU enable and function code, and the TX byte stream into the async TX FIFO.
- Runs entirely in the REF clock domain.

Parameters:
- DATA_WIDTH, 8, byte width of RX/TX/register data
- ADDR_WIDTH, 4, register file address width
- ALU_OUT_WIDTH, 16, ALU result width; must equal 2*DATA_WIDTH
- FUN_WIDTH, 4, ALU function code width

Ports:
- CLK  in  1  system (REF) clock
- RST  in  1  asynchronous, active-low reset
- RX_P_DATA  in  DATA_WIDTH  received byte
- RX_D_VLD  in  1  single-cycle strobe, RX_P_DATA valid
- RdData  in  DATA_WIDTH  register file read data
- RdData_Valid  in  1  register file read data valid
- ALU_OUT  in  ALU_OUT_WIDTH  ALU result
- ALU_OUT_VLD  in  1  ALU result valid
- FIFO_FULL  in  1  TX FIFO full; no write allowed while high
- WrEn  out  1  register file write strobe
- RdEn  out  1  register file read strobe
- Address  out  ADDR_WIDTH  register file address
- WrData  out  DATA_WIDTH  register file write data
- ALU_EN  out  1  ALU operation strobe
- ALU_FUN  out  FUN_WIDTH  ALU function select
- CLK_EN  out  1  ALU clock-gate enable
- TX_P_DATA  out  DATA_WIDTH  byte to TX FIFO
- TX_D_VLD  out  1  TX FIFO write strobe

Behaviour:
- Reset
  - All outputs 0.
  - FSM goes to IDLE.
  - Internal address, result and byte registers cleared.
  - Assertion in any state aborts the command in progress; no partial strobes are emitted after reset.
- Registered outputs
  - All outputs are registered.
  - WrEn, RdEn, ALU_EN and TX_D_VLD are single-cycle pulses.
  - WrEn and RdEn are never high in the same cycle. The register file ignores both-high, so this is mandatory.
- Opcodes (accepted in IDLE on RX_D_VLD)
  - 0xAA register write
  - 0xBB register read
  - 0xCC ALU with operands
  - 0xDD ALU without operands
  - Any other byte in IDLE is discarded and the FSM stays in IDLE.
- Write command (0xAA)
  - IDLE -> WR_ADDR.
  - Next RX byte: Address <= byte[ADDR_WIDTH-1:0], upper bits ignored -> WR_DATA.
  - Next RX byte: WrData <= byte, WrEn=1 for one cycle -> IDLE.
  - No TX response.
- Read command (0xBB)
  - IDLE -> RD_ADDR.
  - Next RX byte: Address latched, RdEn=1 for one cycle -> RD_WAIT.
  - RD_WAIT: on RdData_Valid, capture RdData -> TX_RD.
  - TX_RD: in the first cycle with FIFO_FULL=0, TX_P_DATA <= captured byte, TX_D_VLD=1 -> IDLE.
  - While FIFO_FULL=1, hold the state and emit nothing.
- ALU with operands (0xCC)
  - IDLE -> OPA.
  - Next RX byte: write it to address 0 (WrEn pulse) -> OPB.
  - Next RX byte: write it to address 1 (WrEn pulse) -> FUN.
- ALU without operands (0xDD)
  - IDLE -> FUN.
- FUN and ALU_WAIT
  - FUN, next RX byte: ALU_FUN <= byte[FUN_WIDTH-1:0], ALU_EN=1 for one cycle, CLK_EN=1 -> ALU_WAIT.
  - CLK_EN stays high from the FUN byte until ALU_OUT_VLD is seen, then drops the following cycle.
  - ALU_WAIT: on ALU_OUT_VLD, capture ALU_OUT -> TX_LSB.
- ALU result transmit
  - TX_LSB sends ALU_OUT[7:0], then TX_MSB sends ALU_OUT[15:8], one TX_D_VLD pulse each.
  - Each byte obeys the FIFO_FULL stall rule.
  - The two bytes are never sent in the same cycle; the minimum spacing is 1 cycle.
  - TX_MSB -> IDLE.
- RX during busy states
  - RX_D_VLD in RD_WAIT, ALU_WAIT, TX_RD, TX_LSB or TX_MSB: the byte is dropped. It is not queued.
- Latency
  - Write: WrEn 1 cycle after the data-byte strobe.
  - Read: RdEn 1 cycle after the address-byte strobe.
  - Read response: TX_D_VLD 1 cycle after RdData_Valid when the FIFO is not full.
- Simultaneous events
  - RdData_Valid or ALU_OUT_VLD arriving outside the corresponding WAIT state is ignored.

Decomposition:
- Package sys_ctrl_pkg holds:
  - opcode constants CMD_RF_WR=8'hAA, CMD_RF_RD=8'hBB, CMD_ALU_OP=8'hCC, CMD_ALU_NOP=8'hDD
  - state enum: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, TX_RD, OPA, OPB, FUN, ALU_WAIT, TX_LSB, TX_MSB
  - operand addresses OPA_ADDR=0, OPB_ADDR=1
- Single module; no sub-module is warranted.

Test Plan:
- Write: RX AA,05,3C -> one WrEn pulse with Address=5, WrData=0x3C. No TX_D_VLD.
- Read with FIFO_FULL=1 for 3 cycles: RX BB,05, register file returns 0x3C -> RdEn once, Address=5. TX_D_VLD held off until FIFO_FULL=0, then exactly one pulse with TX_P_DATA=0x3C.
- ALU with operands: RX CC,10,20,00, ALU_OUT=0x0030 -> WrEn to addr 0 (0x10) then addr 1 (0x20), ALU_EN with ALU_FUN=0. TX bytes 0x30 then 0x00; CLK_EN low afterwards.
- ALU without operands: RX DD,02, ALU_OUT=0x1234 -> ALU_EN with ALU_FUN=2, no WrEn. TX 0x34 then 0x12.
- Unknown and busy bytes: RX 7E in IDLE -> no strobes. RX BB,03 then 55 during RD_WAIT -> 55 is dropped and only the read response is sent.
- Reset mid-op: RST low after AA,05 -> outputs 0. A subsequent data byte 0x99 produces no WrEn.
